// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states and the fetch buffer entry.
package fetch_pkg;

    localparam int unsigned FETCH_INST_BYTES = 4;
    localparam int unsigned FETCH_ADDR_W     = 32;
    localparam int unsigned FETCH_DATA_W     = 32;

    typedef enum logic [1:0] {
        FETCH_IDLE,
        FETCH_REQ,
        FETCH_WAIT
    } fetch_state_t;

    typedef struct packed {
        logic                    valid;
        logic [FETCH_ADDR_W-1:0] addr;
        logic [FETCH_DATA_W-1:0] data;
        logic                    err;
    } fetch_ent_t;

endpackage

// File: rtl/fetch_buf.sv
// One fetch buffer entry with an address-match output. A write takes priority
// over an invalidate issued in the same cycle.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    wr_i,
    input  fetch_ent_t              ent_i,
    input  logic                    inv_i,
    input  logic [FETCH_ADDR_W-1:0] addr_i,
    output fetch_ent_t              ent_o,
    output logic                    hit_o
);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ent_o <= '0;
        end else if (wr_i) begin
            ent_o <= ent_i;
        end else if (inv_i) begin
            ent_o.valid <= 1'b0;
        end
    end

    assign hit_o = ent_o.valid && (ent_o.addr == addr_i);

endmodule

// File: rtl/fetch.sv
// Instruction fetch unit: buffers the instruction at pc_i and masters the imem bus.
// Define FETCH_PREFETCH_EN to add a second entry that prefetches pc_i+4.
module fetch
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_LEN = 32,
    parameter int unsigned INST_LEN = 32
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic [ADDR_LEN-1:0] pc_i,
    output logic [INST_LEN-1:0] inst_o,
    output logic                inst_valid_o,
    output logic                fetch_fault_o,
    output logic                imem_req_o,
    output logic [ADDR_LEN-1:0] imem_addr_o,
    input  logic                imem_gnt_i,
    input  logic                imem_rvalid_i,
    input  logic [INST_LEN-1:0] imem_rdata_i,
    input  logic                imem_err_i
);

    // The buffer entry layout is fixed by the package, so widths must agree with it.
    if (INST_LEN != FETCH_DATA_W || ADDR_LEN != FETCH_ADDR_W) begin : g_bad_cfg
        $error("fetch: INST_LEN must be 32 and ADDR_LEN must equal FETCH_ADDR_W");
    end

    fetch_state_t        state, state_d;
    logic [ADDR_LEN-1:0] addr_d;
    fetch_ent_t          cur, cur_in, rsp, sel;
    logic                cur_hit, cur_wr, cur_inv, sel_hit;
    logic                misaligned, rsp_take;

    assign misaligned = pc_i[1:0] != 2'b00;
    assign rsp_take   = (state == FETCH_WAIT) && imem_rvalid_i;
    assign rsp        = '{valid: 1'b1, addr: imem_addr_o, data: imem_rdata_i, err: imem_err_i};
    assign imem_req_o = (state == FETCH_REQ);
    assign cur_inv    = 1'b0;

    fetch_buf u_cur (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .wr_i      (cur_wr),
        .ent_i     (cur_in),
        .inv_i     (cur_inv),
        .addr_i    (pc_i),
        .ent_o     (cur),
        .hit_o     (cur_hit)
    );

`ifdef FETCH_PREFETCH_EN
    fetch_ent_t          nxt;
    logic                nxt_hit, nxt_seq, pf, pf_d;
    logic [ADDR_LEN-1:0] pc_seq;

    assign pc_seq  = pc_i + ADDR_LEN'(FETCH_INST_BYTES);
    assign nxt_seq = nxt.valid && (nxt.addr == pc_seq);

    // Promotion of nxt into cur wins over a demand response landing in cur the same cycle.
    assign cur_wr  = nxt_hit || (rsp_take && !pf);
    assign cur_in  = nxt_hit ? nxt : rsp;
    assign sel     = nxt_hit ? nxt : cur;
    assign sel_hit = cur_hit || nxt_hit;

    fetch_buf u_nxt (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .wr_i      (rsp_take && pf),
        .ent_i     (rsp),
        .inv_i     (nxt_hit),
        .addr_i    (pc_i),
        .ent_o     (nxt),
        .hit_o     (nxt_hit)
    );
`else
    assign cur_wr  = rsp_take;
    assign cur_in  = rsp;
    assign sel     = cur;
    assign sel_hit = cur_hit;
`endif

    assign inst_o        = sel.data;
    assign inst_valid_o  = sel_hit && !sel.err;
    assign fetch_fault_o = misaligned || (sel_hit && sel.err);

    always_comb begin
        state_d = state;
        addr_d  = imem_addr_o;
`ifdef FETCH_PREFETCH_EN
        pf_d    = pf;
`endif
        unique case (state)
            FETCH_IDLE: begin
                if (!misaligned && !sel_hit) begin
                    state_d = FETCH_REQ;
                    addr_d  = pc_i;
`ifdef FETCH_PREFETCH_EN
                    pf_d    = 1'b0;
                end else if (sel_hit && !nxt_seq) begin
                    state_d = FETCH_REQ;
                    addr_d  = pc_seq;
                    pf_d    = 1'b1;
`endif
                end
            end
            FETCH_REQ: begin
                if (imem_gnt_i) state_d = FETCH_WAIT;
            end
            FETCH_WAIT: begin
                if (imem_rvalid_i) state_d = FETCH_IDLE;
            end
            default: state_d = FETCH_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= FETCH_IDLE;
            imem_addr_o <= '0;
`ifdef FETCH_PREFETCH_EN
            pf          <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            imem_addr_o <= addr_d;
`ifdef FETCH_PREFETCH_EN
            pf          <= pf_d;
`endif
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch (default build): bus responder plus a model that
// remembers the last completed fetch and predicts the fetch unit's outputs from it.
module tb_fetch;

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic [31:0] pc_i;
    logic [31:0] inst_o;
    logic        inst_valid_o;
    logic        fetch_fault_o;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        imem_err_i;

    always #5 clk = ~clk;

    fetch #(.ADDR_LEN(32), .INST_LEN(32)) dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n_i),
        .pc_i          (pc_i),
        .inst_o        (inst_o),
        .inst_valid_o  (inst_valid_o),
        .fetch_fault_o (fetch_fault_o),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .imem_err_i    (imem_err_i)
    );

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Model state: the most recently completed fetch, and the bus transaction in flight.
    logic        m_valid, m_err, outstanding, req_prev;
    logic [31:0] m_addr, m_data, pend, addr_prev, stable_pc;
    logic [31:0] hist[$];
    int unsigned gnt_lat, rsp_lat, req_cnt, rsp_cnt, stable_cnt, nreq;
    bit          rand_lat, spur_en;

    function automatic logic [31:0] mem(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h0000_0001;
            32'h8:   return 32'h0000_DEAD;
            default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        endcase
    endfunction

    function automatic logic errf(input logic [31:0] a);
        return a[7:0] == 8'h0C;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_addr = '0; m_data = '0; m_err = 1'b0;
        outstanding = 1'b0; pend = '0; req_cnt = 0; rsp_cnt = 0;
        req_prev = 1'b0; addr_prev = '0; stable_cnt = 0;
        hist.delete();
    endtask

    task automatic respond();
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = $urandom;
        imem_err_i    = 1'($urandom_range(0, 1));
        if (!reset_n_i) return;
        if (imem_req_o) begin
            if (rand_lat && req_cnt == 0) gnt_lat = $urandom_range(0, 3);
            imem_gnt_i = (req_cnt >= gnt_lat);
            req_cnt++;
        end else begin
            req_cnt = 0;
        end
        if (outstanding) begin
            if (rsp_cnt >= rsp_lat) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = mem(pend);
                imem_err_i    = errf(pend);
            end
            rsp_cnt++;
        end else if (spur_en && $urandom_range(0, 7) == 0) begin
            imem_rvalid_i = 1'b1;
        end
    endtask

    // One clock cycle: check outputs mid-cycle, advance the model at the edge, drive the bus.
    task automatic cyc();
        logic        ev_gnt, ev_rsp, hit, found;
        logic [31:0] gaddr;
        ev_gnt = 1'b0; ev_rsp = 1'b0; gaddr = '0;
        #1;
        if (reset_n_i) begin
            hit = m_valid && (m_addr == pc_i);
            chk("inst_valid", 32'(inst_valid_o), 32'(hit && !m_err));
            chk("fetch_fault", 32'(fetch_fault_o), 32'((pc_i[1:0] != 2'b00) || (hit && m_err)));
            chk("inst", inst_o, m_data);
            if (hist.size() == 0 || hist[$] != pc_i) hist.push_back(pc_i);
            if (imem_req_o) begin
                chk("one_outstanding", 32'(outstanding), 32'd0);
                if (req_prev) chk("addr_stable", imem_addr_o, addr_prev);
            end
            req_prev  = imem_req_o;
            addr_prev = imem_addr_o;
            if (imem_req_o && imem_gnt_i) begin
                ev_gnt = 1'b1;
                gaddr  = imem_addr_o;
                found  = 1'b0;
                foreach (hist[i]) if (hist[i] == gaddr) found = 1'b1;
                chk("gnt_addr_aligned", 32'(gaddr[1:0]), 32'd0);
                chk("gnt_addr_from_pc", 32'(found), 32'd1);
                req_prev = 1'b0;
            end
            ev_rsp = imem_rvalid_i && outstanding;
            if (pc_i == stable_pc) stable_cnt++;
            else begin
                stable_pc  = pc_i;
                stable_cnt = 0;
            end
            if (stable_cnt == 24 && pc_i[1:0] == 2'b00)
                chk("liveness", 32'(inst_valid_o || fetch_fault_o), 32'd1);
        end
        @(posedge clk);
        if (!reset_n_i) begin
            model_reset();
        end else begin
            if (ev_rsp) begin
                m_valid = 1'b1; m_addr = pend; m_data = mem(pend); m_err = errf(pend);
                outstanding = 1'b0;
            end
            if (ev_gnt) begin
                outstanding = 1'b1; pend = gaddr; rsp_cnt = 0; req_cnt = 0;
                hist.delete();
                if (rand_lat) rsp_lat = $urandom_range(0, 3);
            end
        end
        #1;
        respond();
    endtask

    // kind 0: valid or fault, 1: request raised, 2: transaction outstanding
    task automatic wait_for(input string tag, input int kind);
        int unsigned n;
        bit ok;
        n = 0; ok = 1'b0;
        while (!ok && n < 60) begin
            cyc();
            #1;
            n++;
            case (kind)
                0:       ok = inst_valid_o || fetch_fault_o;
                1:       ok = imem_req_o;
                default: ok = outstanding;
            endcase
        end
        if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_inst"}, inst_o, 32'd0);
        chk({tag, "_valid"}, 32'(inst_valid_o), 32'd0);
        chk({tag, "_fault"}, 32'(fetch_fault_o), 32'd0);
        chk({tag, "_req"}, 32'(imem_req_o), 32'd0);
        chk({tag, "_addr"}, imem_addr_o, 32'd0);
    endtask

    initial begin
        reset_n_i = 1'b0; pc_i = '0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; imem_err_i = 1'b0;
        gnt_lat = 0; rsp_lat = 0; rand_lat = 1'b0; spur_en = 1'b0; stable_pc = '0;
        model_reset();
        repeat (2) cyc();
        #1;
        chk_reset_values("reset");
        reset_n_i = 1'b1;

        // First fill at 0, then step to 4
        wait_for("t1_req", 1);
        chk("t1_addr", imem_addr_o, 32'h0);
        wait_for("t1_fill", 0);
        chk("t1_valid", 32'(inst_valid_o), 32'd1);
        chk("t1_inst", inst_o, 32'h1);
        pc_i = 32'h4;
        #1;
        chk("t2_valid_drop", 32'(inst_valid_o), 32'd0);
        wait_for("t2_req", 1);
        chk("t2_addr", imem_addr_o, 32'h4);
        wait_for("t2_fill", 0);
        chk("t2_inst", inst_o, mem(32'h4));

        // Redirect while the response for 0x8 is in flight
        rsp_lat = 2;
        pc_i = 32'h8;
        wait_for("t3_wait", 2);
        pc_i = 32'h40;
        wait_for("t3_req", 1);
        chk("t3_stale_invalid", 32'(inst_valid_o), 32'd0);
        chk("t3_addr", imem_addr_o, 32'h40);
        wait_for("t3_fill", 0);
        chk("t3_valid", 32'(inst_valid_o), 32'd1);
        chk("t3_inst", inst_o, mem(32'h40));
        rsp_lat = 0;

        // Misaligned pc and bus error
        pc_i = 32'h6;
        nreq = 0;
        repeat (10) begin cyc(); if (imem_req_o) nreq++; end
        #1;
        chk("t4_fault", 32'(fetch_fault_o), 32'd1);
        chk("t4_no_req", nreq, 32'd0);
        pc_i = 32'hC;
        wait_for("t4_err", 0);
        chk("t4_err_fault", 32'(fetch_fault_o), 32'd1);
        chk("t4_err_valid", 32'(inst_valid_o), 32'd0);

        // Hold: static pc means no bus traffic
        pc_i = 32'h10;
        wait_for("t5_fill", 0);
        nreq = 0;
        repeat (20) begin cyc(); if (imem_req_o) nreq++; end
        #1;
        chk("t5_no_req", nreq, 32'd0);
        chk("t5_valid_held", 32'(inst_valid_o), 32'd1);

        // Reset while waiting for a response; the late response must be dropped
        rsp_lat = 60;
        pc_i = 32'h20;
        wait_for("t6_wait", 2);
        cyc();
        reset_n_i = 1'b0;
        #1;
        chk_reset_values("t6_reset");
        cyc(); cyc();
        gnt_lat = 50; rsp_lat = 0;
        reset_n_i = 1'b1;
        cyc();
        imem_rvalid_i = 1'b1; imem_rdata_i = 32'hDEAD_BEEF; imem_err_i = 1'b0;
        cyc(); cyc();
        #1;
        chk("t6_late_dropped", 32'(inst_valid_o), 32'd0);
        gnt_lat = 0;
        wait_for("t6_fill", 0);
        chk("t6_inst", inst_o, mem(32'h20));

        // Randomised pc traffic with random bus latencies and stray rvalids
        rand_lat = 1'b1; spur_en = 1'b1;
        repeat (250) begin
            case ($urandom_range(0, 9))
                0:       pc_i = $urandom | 32'h1;
                1:       pc_i = $urandom & ~32'h3;
                2:       pc_i = (pc_i + 32'h4) & ~32'h3;
                default: pc_i = 32'($urandom_range(0, 15)) << 2;
            endcase
            repeat ($urandom_range(1, 30)) cyc();
        end
        spur_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
